// File: rtl/dealer_pkg.sv
// Shared definitions for the card dealer.
//   state_t         : dealer FSM states
//   RANK_MIN/MAX    : legal card ranks (ace = 1 .. king = 13)
//   CARDS_PER_RANK  : copies of each rank in one deck
//   next_rank()     : rank successor with wrap 13 -> 1, used by the fallback scan
package dealer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SHUFFLE = 3'd1,
    ST_SAMPLE  = 3'd2,
    ST_CHECK   = 3'd3,
    ST_SCAN    = 3'd4,
    ST_GRANT   = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

  localparam logic [3:0] RANK_MIN       = 4'd1;
  localparam logic [3:0] RANK_MAX       = 4'd13;
  localparam int         CARDS_PER_RANK = 4;

  function automatic logic [3:0] next_rank(input logic [3:0] r);
    return (r >= RANK_MAX) ? RANK_MIN : r + 4'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req   : request vector, one bit per requester
//   ptr   : index of the requester with highest priority this round
//   grant : one-hot grant (all zero when req == 0)
//   idx   : index of the granted requester (0 when req == 0)
// The caller registers the result.
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  always_comb begin
    logic found;
    int   k;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    // Walk requesters starting at ptr, wrapping; first hit wins.
    for (int i = 0; i < N; i++) begin
      k = (int'(ptr) + i) % N;
      if (!found && req[k]) begin
        found    = 1'b1;
        grant[k] = 1'b1;
        idx      = IW'(k);
      end
    end
  end

endmodule

// File: rtl/card_dealer.sv
// Card dealer: shares one random rank source between several requesters and
// keeps per-rank usage counts so no rank is dealt more than
// CARDS_PER_RANK*NUM_DECKS times per shoe.
//   clk        : system clock
//   rst        : asynchronous active-low reset
//   rnd        : random rank, new value every cycle (0, 14, 15 are invalid)
//   shuffle    : one-cycle pulse, refills the shoe (deferred if busy)
//   req        : per-requester level request, held until ack
//   ack        : one-hot grant pulse, card valid in the same cycle
//   card       : dealt rank 1..13, held until the next ack
//   busy       : high whenever the FSM is not idle
//   deck_empty : high when no cards remain
//   cards_left : cards remaining in the shoe
module card_dealer
  import dealer_pkg::*;
#(
  parameter  int NUM_REQ   = 2,
  parameter  int NUM_DECKS = 1,
  parameter  int MAX_TRIES = 8,
  localparam int CL_W      = $clog2(52 * NUM_DECKS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         rnd,
  input  logic               shuffle,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] ack,
  output logic [3:0]         card,
  output logic               busy,
  output logic               deck_empty,
  output logic [CL_W-1:0]    cards_left
);

  localparam int IW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PER_RANK = CARDS_PER_RANK * NUM_DECKS;
  localparam int UW       = $clog2(PER_RANK + 1);
  localparam int TW       = $clog2(MAX_TRIES + 1);
  localparam logic [CL_W-1:0] FULL_SHOE = CL_W'(52 * NUM_DECKS);

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IW-1:0]        g_q, g_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [3:0]           card_q, card_d;
  logic [3:0]           cand_q, cand_d;
  logic [TW-1:0]        tries_q, tries_d;
  logic                 pend_q, pend_d;
  logic                 busy_q, busy_d;
  logic                 empty_q, empty_d;
  logic [CL_W-1:0]      left_q, left_d;
  // Indexed directly by the 4-bit rank; entries 0, 14, 15 stay at zero.
  logic [UW-1:0]        used_q [16];
  logic [UW-1:0]        used_d [16];

  logic [NUM_REQ-1:0]   arb_grant;
  logic [IW-1:0]        arb_idx;
  logic                 cand_valid;
  logic                 cand_ok;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req   (req),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  assign cand_valid = (cand_q >= RANK_MIN) && (cand_q <= RANK_MAX);
  assign cand_ok    = cand_valid && (used_q[cand_q] < UW'(PER_RANK));

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    grant_d = grant_q;
    g_d     = g_q;
    ptr_d   = ptr_q;
    card_d  = card_q;
    cand_d  = cand_q;
    tries_d = tries_q;
    pend_d  = pend_q;
    left_d  = left_q;
    for (int r = 0; r < 16; r++) used_d[r] = used_q[r];

    // A shuffle arriving mid-deal is remembered and run on return to idle.
    if (shuffle && (state_q != ST_IDLE) && (state_q != ST_SHUFFLE)) pend_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (shuffle || pend_q) begin
          state_d = ST_SHUFFLE;
        end else if ((req != '0) && !empty_q) begin
          grant_d = arb_grant;
          g_d     = arb_idx;
          tries_d = '0;
          state_d = ST_SAMPLE;
        end
      end
      ST_SHUFFLE: begin
        for (int r = 0; r < 16; r++) used_d[r] = '0;
        left_d  = FULL_SHOE;
        pend_d  = 1'b0;
        state_d = ST_IDLE;
      end
      ST_SAMPLE: begin
        cand_d  = rnd;
        tries_d = tries_q + TW'(1);
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (cand_ok) begin
          ack_d   = grant_q;
          card_d  = cand_q;
          state_d = ST_GRANT;
        end else if (tries_q == TW'(MAX_TRIES)) begin
          if (!cand_valid) cand_d = RANK_MIN;
          state_d = ST_SCAN;
        end else begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SCAN: begin
        // Deck is non-empty, so some rank is available within 13 steps.
        if (cand_ok) begin
          ack_d   = grant_q;
          card_d  = cand_q;
          state_d = ST_GRANT;
        end else begin
          cand_d = next_rank(cand_q);
        end
      end
      ST_GRANT: begin
        ack_d          = '0;
        used_d[cand_q] = used_q[cand_q] + UW'(1);
        left_d         = left_q - CL_W'(1);
        ptr_d          = (g_q == IW'(NUM_REQ - 1)) ? '0 : g_q + IW'(1);
        state_d        = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d  = (state_d != ST_IDLE);
    empty_d = (left_d == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ack_q   <= '0;
      grant_q <= '0;
      g_q     <= '0;
      ptr_q   <= '0;
      card_q  <= '0;
      cand_q  <= '0;
      tries_q <= '0;
      pend_q  <= 1'b0;
      busy_q  <= 1'b0;
      empty_q <= 1'b0;
      left_q  <= FULL_SHOE;
      for (int r = 0; r < 16; r++) used_q[r] <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      grant_q <= grant_d;
      g_q     <= g_d;
      ptr_q   <= ptr_d;
      card_q  <= card_d;
      cand_q  <= cand_d;
      tries_q <= tries_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
      empty_q <= empty_d;
      left_q  <= left_d;
      for (int r = 0; r < 16; r++) used_q[r] <= used_d[r];
    end
  end

  assign ack        = ack_q;
  assign card       = card_q;
  assign busy       = busy_q;
  assign deck_empty = empty_q;
  assign cards_left = left_q;

endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer: random rank streams are replayed
// against a shoe model (remaining count per rank) that predicts the dealt
// card, the grantee and the cycle of the ack.
module tb_card_dealer;

  localparam int M = 8;

  logic       clk;
  logic       rst;
  logic [3:0] rnd;
  logic       shuffle;
  logic [1:0] req;
  logic [1:0] ack;
  logic [3:0] card;
  logic       busy;
  logic       deck_empty;
  logic [5:0] cards_left;

  card_dealer dut (
    .clk        (clk),
    .rst        (rst),
    .rnd        (rnd),
    .shuffle    (shuffle),
    .req        (req),
    .ack        (ack),
    .card       (card),
    .busy       (busy),
    .deck_empty (deck_empty),
    .cards_left (cards_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Shoe model.
  int         left [14];
  int         total;
  int         ptr_m;
  logic [3:0] seq_g [64];

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void refill();
    for (int r = 0; r < 14; r++) left[r] = (r == 0) ? 0 : 4;
    total = 52;
  endfunction

  function automatic void fill_const(input logic [3:0] v);
    for (int i = 0; i < 64; i++) seq_g[i] = v;
  endfunction

  function automatic void fill_rand();
    for (int i = 0; i < 64; i++) seq_g[i] = 4'($urandom_range(0, 15));
  endfunction

  // Samples are taken from the rnd value present at edges 1,3,5,.. after the
  // idle edge; the k-th sample, if usable, is acked after edge 2k. After M
  // failures the shoe is scanned upward from the last sample (or from 1).
  function automatic void predict(output int c_out, output int n_out);
    logic [3:0] v;
    int c;
    v = 4'd0;
    c_out = 0;
    n_out = -1;
    for (int k = 1; k <= M; k++) begin
      v = seq_g[2*k-1];
      if (v >= 1 && v <= 13 && left[v] > 0) begin
        c_out = int'(v);
        n_out = 2 * k;
        return;
      end
    end
    c = (v >= 1 && v <= 13) ? int'(v) : 1;
    for (int j = 0; j < 13; j++) begin
      if (left[c] > 0) begin
        c_out = c;
        n_out = 2 * M + 1 + j;
        return;
      end
      c = (c == 13) ? 1 : c + 1;
    end
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with it idle.
  task automatic deal(input logic [1:0] mask, input int shuf_edge, output int got_card);
    int  exp_card, exp_n, exp_g, n;
    bit  seen;
    exp_g = mask[ptr_m] ? ptr_m : 1 - ptr_m;
    predict(exp_card, exp_n);
    req  = mask;
    rnd  = seq_g[0];
    seen = 1'b0;
    n    = 0;
    got_card = 0;
    while (!seen && n < 48) begin
      if (n == shuf_edge) shuffle = 1'b1;
      @(posedge clk);
      @(negedge clk);
      shuffle = 1'b0;
      rnd = seq_g[n+1];
      if (ack != 2'b00) begin
        seen = 1'b1;
        got_card = int'(card);
        check_val("ack_cycle", n, exp_n);
        check_val("ack_onehot", int'(ack), 1 << exp_g);
        check_val("card", int'(card), exp_card);
        req = 2'b00;
      end
      n++;
    end
    if (!seen) begin
      check_val("ack_timeout", 0, 1);
      req = 2'b00;
    end else begin
      left[exp_card]--;
      total--;
      ptr_m = (exp_g + 1) % 2;
    end
    @(posedge clk);
    @(negedge clk);
    check_val("done_ack", int'(ack), 0);
    check_val("done_cards_left", int'(cards_left), total);
    @(posedge clk);
    @(negedge clk);
    check_val("idle_busy", int'(busy), 0);
    check_val("idle_cards_left", int'(cards_left), total);
    check_val("idle_deck_empty", int'(deck_empty), (total == 0) ? 1 : 0);
    $display("deal mask=%b grantee=%0d card=%0d expected=%0d cards_left=%0d", mask, exp_g,
             got_card, exp_card, cards_left);
  endtask

  // Shuffle pulse from idle: one SHUFFLE cycle, then idle with a full shoe.
  task automatic do_shuffle();
    shuffle = 1'b1;
    @(posedge clk);
    @(negedge clk);
    shuffle = 1'b0;
    check_val("shuffle_busy", int'(busy), 1);
    @(posedge clk);
    @(negedge clk);
    refill();
    check_val("shuffle_cards_left", int'(cards_left), 52);
    check_val("shuffle_deck_empty", int'(deck_empty), 0);
    $display("shuffle cards_left=%0d", cards_left);
  endtask

  initial begin
    int c;
    int guard;
    rst = 1'b0;
    req = 2'b00;
    rnd = 4'd0;
    shuffle = 1'b0;
    refill();
    ptr_m = 0;
    for (int i = 0; i < 64; i++) seq_g[i] = 4'd0;

    repeat (3) @(negedge clk);
    check_val("rst_ack", int'(ack), 0);
    check_val("rst_card", int'(card), 0);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_cards_left", int'(cards_left), 52);
    check_val("rst_deck_empty", int'(deck_empty), 0);
    rst = 1'b1;
    @(negedge clk);

    // Single player request with rnd held at 5.
    fill_const(4'd5);
    deal(2'b01, -1, c);
    check_val("first_card", c, 5);
    check_val("first_cards_left", int'(cards_left), 51);

    // Both requesters held: grants alternate.
    for (int d = 0; d < 4; d++) begin
      fill_rand();
      deal(2'b11, -1, c);
    end

    // Rank exhaustion with rnd stuck at 7, plus invalid samples.
    do_shuffle();
    for (int d = 0; d < 5; d++) begin
      fill_const(4'd7);
      if (d == 0) begin
        seq_g[1] = 4'd0;
        seq_g[3] = 4'd14;
      end
      deal(2'b01, -1, c);
      check_val("rank7_card", c, (d < 4) ? 7 : 8);
    end

    // Drain the shoe with random requests and streams.
    guard = 0;
    while (total > 0 && guard < 80) begin
      fill_rand();
      deal(2'($urandom_range(1, 3)), -1, c);
      guard++;
    end
    check_val("drain_deck_empty", int'(deck_empty), 1);
    check_val("drain_cards_left", int'(cards_left), 0);

    // Empty shoe: request waits with no ack until a shuffle.
    req = 2'b01;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_val("empty_no_ack", int'(ack), 0);
    end
    do_shuffle();
    fill_rand();
    deal(2'b01, -1, c);

    // Shuffle pulse during SAMPLE is deferred until after the deal.
    fill_rand();
    deal(2'b10, 1, c);
    @(posedge clk);
    @(negedge clk);
    check_val("pend_shuffle_busy", int'(busy), 1);
    @(posedge clk);
    @(negedge clk);
    refill();
    check_val("pend_cards_left", int'(cards_left), 52);
    $display("pending shuffle cards_left=%0d", cards_left);

    // Reset asserted while scanning aborts the deal.
    fill_const(4'd5);
    deal(2'b01, -1, c);
    req = 2'b01;
    rnd = 4'd0;
    repeat (2 * M + 1) begin
      @(posedge clk);
      @(negedge clk);
      check_val("scan_pre_ack", int'(ack), 0);
    end
    check_val("scan_busy", int'(busy), 1);
    check_val("scan_cards_left", int'(cards_left), 51);
    rst = 1'b0;
    #1;
    check_val("async_ack", int'(ack), 0);
    check_val("async_busy", int'(busy), 0);
    check_val("async_cards_left", int'(cards_left), 52);
    check_val("async_card", int'(card), 0);
    $display("reset during scan ack=%b busy=%0d cards_left=%0d", ack, busy, cards_left);
    req = 2'b00;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
